branch_cmp_bht: RTL

Branch resolution unit for the pipelined MIPS core.
- Parametrised-width comparator that evaluates the branch condition in ID. Unlike the previous comparator, all eight condition codes are defined (no latched/undefined codes).
- Contains a 2-bit saturating branch history table (BHT) that supplies a taken prediction to IF.
- Flags mispredictions and keeps saturating branch/miss statistics counters.

---
 rtl/branch_cmp_bht.sv | 113 +++++++++++
 1 files changed

// File: rtl/branch_cmp_bht.sv
// Branch resolution unit: full-width branch comparator, 2-bit saturating
// branch history table for IF-stage prediction, and misprediction statistics.
module branch_cmp_bht #(
    parameter int         WIDTH    = 32,
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] INIT_CTR = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [2:0]       cmp_sel,
    output logic             cmp_out,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_pred,
    output logic             mispredict,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int               ENTRIES  = 32'sd1 << IDX_BITS;
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [1:0]          bht_r [ENTRIES];
    logic [CNT_W-1:0]    branch_cnt_r;
    logic [CNT_W-1:0]    miss_cnt_r;
    logic                cmp_s;
    logic [1:0]          ctr_nxt_s;
    logic [IDX_BITS-1:0] lookup_idx_s;
    logic [IDX_BITS-1:0] res_idx_s;
    logic                unused_pc_bits;

    // Upper PC bits are deliberately dropped, so distant branches alias.
    assign lookup_idx_s   = lookup_pc[IDX_BITS+1:2];
    assign res_idx_s      = res_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                              res_pc[31:IDX_BITS+2], res_pc[1:0]};

    // Branch condition decode; every code is defined so nothing latches.
    always_comb begin
        cmp_s = 1'b0;
        case (cmp_sel)
            3'd0:    cmp_s = (d1 == d2);
            3'd1:    cmp_s = (d1 != d2);
            3'd2:    cmp_s = ~d1[WIDTH-1];
            3'd3:    cmp_s = d1[WIDTH-1] | (d1 == ZERO_W);
            3'd4:    cmp_s = ~d1[WIDTH-1] & (d1 != ZERO_W);
            3'd5:    cmp_s = d1[WIDTH-1];
            3'd6:    cmp_s = (d1 < d2);
            3'd7:    cmp_s = ($signed(d1) < $signed(d2));
            default: cmp_s = 1'b0;
        endcase
    end

    // Saturating next value for the entry addressed by the resolving branch.
    always_comb begin
        ctr_nxt_s = bht_r[res_idx_s];
        if (cmp_s) begin
            if (bht_r[res_idx_s] != 2'b11) begin
                ctr_nxt_s = bht_r[res_idx_s] + 2'b01;
            end else begin
                ctr_nxt_s = bht_r[res_idx_s];
            end
        end else begin
            if (bht_r[res_idx_s] != 2'b00) begin
                ctr_nxt_s = bht_r[res_idx_s] - 2'b01;
            end else begin
                ctr_nxt_s = bht_r[res_idx_s];
            end
        end
    end

    // History table; lookups read the pre-update value (no bypass).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_r[i] <= INIT_CTR;
            end
        end else if (res_valid) begin
            bht_r[res_idx_s] <= ctr_nxt_s;
        end
    end

    // Saturating statistics; clear wins over increments.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            branch_cnt_r <= CNT_ZERO;
            miss_cnt_r   <= CNT_ZERO;
        end else begin
            if (res_valid && (branch_cnt_r != CNT_MAX)) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end
            if (mispredict && (miss_cnt_r != CNT_MAX)) begin
                miss_cnt_r <= miss_cnt_r + CNT_ONE;
            end
        end
    end

    assign cmp_out    = cmp_s;
    assign pred_taken = bht_r[lookup_idx_s][1];
    assign mispredict = res_valid & (cmp_s != res_pred);
    assign branch_cnt = branch_cnt_r;
    assign miss_cnt   = miss_cnt_r;

endmodule
